instruction_parser: RTL

INSTRUCTION_PARSER -- requirements
Module: instruction_parser

---
 rtl/instruction_parser.sv | 349 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/instruction_parser.sv
`default_nettype none
// ============================================================================
// Module   : instruction_parser
// Purpose  : Streaming ASCII line parser for "turn on / turn off / toggle
//            r0,c0 through r1,c1" puzzle text. Each accepted line becomes one
//            packed instruction word: {op, start_row, start_col, end_row,
//            end_col}.
//            A valid line is held in a one-deep stage. It moves to the output
//            when the next valid line completes, or with instr_last=1 when the
//            input ends.
// Ports    : clk            - sole clock, rising edge
//            reset          - asynchronous, active-high
//            inbound_*      - byte stream (valid/ready/data/last)
//            instr_*        - instruction stream (valid/ready/data/last)
//            parse_done     - sticky completion flag
//            malformed_count- (PARSER_MALFORMED_COUNT_EN only) saturating
//                             count of dropped non-blank lines
// Config   : define PARSER_MALFORMED_COUNT_EN to add malformed_count
// Revision : 1.0 - initial release
// ============================================================================
module instruction_parser #(
  parameter int INSTRUCTION_WIDTH = 50
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         inbound_valid,
  output logic                         inbound_ready,
  input  logic [7:0]                   inbound_data,
  input  logic                         inbound_last,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic [INSTRUCTION_WIDTH-1:0] instr_data,
  output logic                         instr_last,
`ifdef PARSER_MALFORMED_COUNT_EN
  output logic [15:0]                  malformed_count,
`endif
  output logic                         parse_done
);

  typedef enum logic [2:0] {
    SM_LINE_START = 3'd0,
    SM_OP_SCAN    = 3'd1,
    SM_NUMBERS    = 3'd2,
    SM_LINE_END   = 3'd3,
    SM_PUSH       = 3'd4,
    SM_FLUSH      = 3'd5,
    SM_FINISHED   = 3'd6
  } state_t;

  localparam logic [7:0] c_ascii_lf  = 8'h0A;
  localparam logic [7:0] c_ascii_cr  = 8'h0D;
  localparam logic [7:0] c_ascii_tab = 8'h09;
  localparam logic [7:0] c_ascii_sp  = 8'h20;
  localparam logic [7:0] c_ascii_0   = 8'h30;
  localparam logic [7:0] c_ascii_9   = 8'h39;
  localparam logic [7:0] c_ascii_o   = 8'h6F;
  localparam logic [7:0] c_ascii_g   = 8'h67;
  localparam logic [7:0] c_ascii_n   = 8'h6E;
  localparam logic [7:0] c_ascii_f   = 8'h66;

  localparam logic [1:0] c_op_turn_off = 2'b00;
  localparam logic [1:0] c_op_toggle   = 2'b01;
  localparam logic [1:0] c_op_turn_on  = 2'b11;

  // Run counter saturates one past the last stored field so that a fifth
  // or later run never maps onto a field slot.
  localparam logic [2:0] c_run_sat = 3'd5;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic        inbound_ready_q, inbound_ready_d;
  logic        instr_valid_q, instr_valid_d;
  logic        instr_last_q, instr_last_d;
  logic [49:0] instr_word_q, instr_word_d;
  logic        parse_done_q, parse_done_d;
  logic [49:0] stage_q, stage_d;
  logic        stage_full_q, stage_full_d;

  // Per-line parse context
  logic        seen_o_q, seen_o_d;
  logic        op_decided_q, op_decided_d;
  logic        op_valid_q, op_valid_d;
  logic [1:0]  op_q, op_d;
  logic        nonblank_q, nonblank_d;
  logic        in_run_q, in_run_d;
  logic [2:0]  run_cnt_q, run_cnt_d;
  logic [11:0] acc_q, acc_d;
  logic [47:0] fields_q, fields_d;
  logic        last_q, last_d;

  // --------------------------------------------------------------------------
  // Byte classification and helpers
  // --------------------------------------------------------------------------
  logic        w_is_digit;
  logic        w_is_space;
  logic        w_is_term;
  logic        w_byte_state;
  logic        w_accept;
  logic [11:0] w_acc_next;
  logic        w_line_valid;
  logic [49:0] w_line_word;
  logic [2:0]  w_run_idx;

  assign w_is_digit = (inbound_data >= c_ascii_0) && (inbound_data <= c_ascii_9);
  assign w_is_space = (inbound_data == c_ascii_sp)  || (inbound_data == c_ascii_tab) ||
                      (inbound_data == c_ascii_cr)  || (inbound_data == c_ascii_lf);
  // A flagged final byte closes its line as though a newline followed it.
  assign w_is_term  = (inbound_data == c_ascii_lf) || inbound_last;

  assign w_byte_state = (state_q == SM_LINE_START) || (state_q == SM_OP_SCAN) ||
                        (state_q == SM_NUMBERS);
  assign w_accept     = inbound_valid && inbound_ready_q && w_byte_state;

  // acc*10 + digit, naturally truncated to 12 bits (modulo 4096).
  assign w_acc_next = in_run_q ?
                      ((acc_q << 3) + (acc_q << 1) + {8'd0, inbound_data[3:0]}) :
                      {8'd0, inbound_data[3:0]};

  assign w_line_valid = op_valid_q && (run_cnt_q >= 3'd4);
  assign w_line_word  = {op_q, fields_q};

  // --------------------------------------------------------------------------
  // Next-state / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    inbound_ready_d = inbound_ready_q;
    instr_valid_d   = instr_valid_q;
    instr_last_d    = instr_last_q;
    instr_word_d    = instr_word_q;
    parse_done_d    = parse_done_q;
    stage_d         = stage_q;
    stage_full_d    = stage_full_q;
    seen_o_d        = seen_o_q;
    op_decided_d    = op_decided_q;
    op_valid_d      = op_valid_q;
    op_d            = op_q;
    nonblank_d      = nonblank_q;
    in_run_d        = in_run_q;
    run_cnt_d       = run_cnt_q;
    acc_d           = acc_q;
    fields_d        = fields_q;
    last_d          = last_q;
    w_run_idx       = 3'd0;

    // Output handshake completes independently of the parse state.
    if (instr_valid_q && instr_ready) begin
      instr_valid_d = 1'b0;
    end

    case (state_q)
      SM_LINE_START, SM_OP_SCAN, SM_NUMBERS: begin
        if (w_accept) begin
          if (!w_is_space) begin
            nonblank_d = 1'b1;
          end

          // Only the byte directly after the first 'o' selects the op.
          if (!op_decided_q) begin
            if (seen_o_q) begin
              op_decided_d = 1'b1;
              case (inbound_data)
                c_ascii_g: begin op_d = c_op_toggle;   op_valid_d = 1'b1; end
                c_ascii_n: begin op_d = c_op_turn_on;  op_valid_d = 1'b1; end
                c_ascii_f: begin op_d = c_op_turn_off; op_valid_d = 1'b1; end
                default:   ;
              endcase
            end else if (inbound_data == c_ascii_o) begin
              seen_o_d = 1'b1;
            end
          end

          in_run_d = w_is_digit;
          if (w_is_digit) begin
            acc_d = w_acc_next;
            if (!in_run_q && (run_cnt_q != c_run_sat)) begin
              run_cnt_d = run_cnt_q + 3'd1;
            end
            // The field is updated on every digit so it always holds the
            // running value of the current run.
            w_run_idx = run_cnt_d - 3'd1;
            case (w_run_idx)
              3'd0:    fields_d[47:36] = w_acc_next;
              3'd1:    fields_d[35:24] = w_acc_next;
              3'd2:    fields_d[23:12] = w_acc_next;
              3'd3:    fields_d[11:0]  = w_acc_next;
              default: ;
            endcase
          end

          if (w_is_term) begin
            last_d  = inbound_last;
            state_d = SM_LINE_END;
          end else if (op_decided_d) begin
            state_d = SM_NUMBERS;
          end else if (nonblank_d) begin
            state_d = SM_OP_SCAN;
          end
        end
      end

      SM_LINE_END: begin
        // Op and fields are left intact: SM_PUSH still needs this line's word.
        seen_o_d     = 1'b0;
        op_decided_d = 1'b0;
        op_valid_d   = 1'b0;
        nonblank_d   = 1'b0;
        in_run_d     = 1'b0;
        run_cnt_d    = 3'd0;
        if (w_line_valid) begin
          if (stage_full_q) begin
            state_d = SM_PUSH;
          end else begin
            stage_d      = w_line_word;
            stage_full_d = 1'b1;
            state_d      = last_q ? SM_FLUSH : SM_LINE_START;
          end
        end else if (last_q) begin
          state_d = stage_full_q ? SM_FLUSH : SM_FINISHED;
        end else begin
          state_d = SM_LINE_START;
        end
      end

      SM_PUSH: begin
        if (!instr_valid_q) begin
          instr_word_d  = stage_q;
          instr_last_d  = 1'b0;
          instr_valid_d = 1'b1;
          stage_d       = w_line_word;
          state_d       = last_q ? SM_FLUSH : SM_LINE_START;
        end
      end

      SM_FLUSH: begin
        if (!instr_valid_q) begin
          instr_word_d  = stage_q;
          instr_last_d  = 1'b1;
          instr_valid_d = 1'b1;
          stage_full_d  = 1'b0;
          state_d       = SM_FINISHED;
        end
      end

      SM_FINISHED: ;

      default: state_d = SM_LINE_START;
    endcase

    inbound_ready_d = !instr_valid_d &&
                      ((state_d == SM_LINE_START) || (state_d == SM_OP_SCAN) ||
                       (state_d == SM_NUMBERS));

    // Done once nothing remains to deliver after the input has ended.
    if ((state_d == SM_FINISHED) && !instr_valid_d) begin
      parse_done_d = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= SM_LINE_START;
      inbound_ready_q <= 1'b0;
      instr_valid_q   <= 1'b0;
      instr_last_q    <= 1'b0;
      instr_word_q    <= 50'd0;
      parse_done_q    <= 1'b0;
      stage_q         <= 50'd0;
      stage_full_q    <= 1'b0;
      seen_o_q        <= 1'b0;
      op_decided_q    <= 1'b0;
      op_valid_q      <= 1'b0;
      op_q            <= 2'b00;
      nonblank_q      <= 1'b0;
      in_run_q        <= 1'b0;
      run_cnt_q       <= 3'd0;
      acc_q           <= 12'd0;
      fields_q        <= 48'd0;
      last_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      inbound_ready_q <= inbound_ready_d;
      instr_valid_q   <= instr_valid_d;
      instr_last_q    <= instr_last_d;
      instr_word_q    <= instr_word_d;
      parse_done_q    <= parse_done_d;
      stage_q         <= stage_d;
      stage_full_q    <= stage_full_d;
      seen_o_q        <= seen_o_d;
      op_decided_q    <= op_decided_d;
      op_valid_q      <= op_valid_d;
      op_q            <= op_d;
      nonblank_q      <= nonblank_d;
      in_run_q        <= in_run_d;
      run_cnt_q       <= run_cnt_d;
      acc_q           <= acc_d;
      fields_q        <= fields_d;
      last_q          <= last_d;
    end
  end

`ifdef PARSER_MALFORMED_COUNT_EN
  // Blank lines never count; only non-blank lines that fail validation do.
  logic [15:0] malformed_count_q, malformed_count_d;
  logic        w_line_malformed;

  assign w_line_malformed = (state_q == SM_LINE_END) && !w_line_valid && nonblank_q;

  always_comb begin
    malformed_count_d = malformed_count_q;
    if (w_line_malformed && (malformed_count_q != 16'hFFFF)) begin
      malformed_count_d = malformed_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      malformed_count_q <= 16'd0;
    end else begin
      malformed_count_q <= malformed_count_d;
    end
  end

  assign malformed_count = malformed_count_q;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign inbound_ready = inbound_ready_q;
  assign instr_valid   = instr_valid_q;
  assign instr_last    = instr_last_q;
  assign parse_done    = parse_done_q;

  generate
    if (INSTRUCTION_WIDTH > 50) begin : g_pad
      assign instr_data = {{(INSTRUCTION_WIDTH-50){1'b0}}, instr_word_q};
    end else begin : g_exact
      assign instr_data = instr_word_q;
    end
  endgenerate

endmodule
`default_nettype wire
